imem_ctrl: RTL and testbench
============================

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-003 SHALL have parameter MAX_STREAK, default 4, meaning the maximum number of consecutive loader grants while a fetch waits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports fetch_req (in, 1), fetch_addr (in, ADDR_W) and fetch_gnt (out, 1): the fetch request port.
REQ-007 SHALL have ports fetch_rvalid (out, 1) and fetch_rdata (out, DATA_W): the fetch read return.
REQ-008 SHALL have ports load_req (in, 1), load_addr (in, ADDR_W), load_wdata (in, DATA_W), load_last (in, 1) and load_gnt (out, 1): the program loader write port.
REQ-009 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W) and mem_rdata (in, DATA_W): the single-port memory, with synchronous read and 1-cycle latency.
REQ-010 SHALL have port boot_done (out, 1): the program image is loaded and fetch is enabled.

Function
REQ-011 SHALL implement FSM states BOOT, RUN and FLUSH.
REQ-012 BOOT: grant the loader only; fetch_gnt SHALL stay 0 regardless of fetch_req.
REQ-013 BOOT->RUN SHALL occur the cycle after a granted load with load_last=1, or after the 2^ADDR_W-th granted load (word counter wrap); boot_done SHALL then read 1.
REQ-014 RUN: at most one grant per cycle; the grant SHALL be combinational from that cycle's requests.
REQ-015 RUN arbitration: the loader has priority unless the streak counter equals MAX_STREAK while fetch_req=1; in that case the fetch is granted and the counter clears.
REQ-016 Streak counter SHALL increment on each loader grant while fetch_req=1, clear on any fetch grant or whenever fetch_req=0, and saturate at MAX_STREAK.
REQ-017 On a grant, mem_en=1 and mem_addr=granted address; for a load, mem_we=1 and mem_wdata=load_wdata; otherwise mem_we=0.
REQ-018 With no grant, mem_en=0 and mem_we=0.
REQ-019 fetch_rvalid SHALL be 1 exactly one cycle after a fetch grant, with fetch_rdata=mem_rdata in that cycle.
REQ-020 RUN->FLUSH SHALL occur on a granted load with load_last=1 (program reload); FLUSH SHALL last exactly one cycle with no grants, then return to RUN.
REQ-021 A fetch granted in the cycle before FLUSH SHALL still return fetch_rvalid; no fetch is granted during FLUSH.
REQ-022 A write followed next cycle by a read of the same address SHALL return the new data, since the memory serialises them.
REQ-023 Simultaneous fetch_req and load_req in BOOT: load granted, fetch held and not counted in the streak.

Reset
REQ-024 While rst=1: state=BOOT, streak=0, word counter=0, and boot_done, fetch_gnt, load_gnt, fetch_rvalid, mem_en and mem_we all 0; fetch_rdata=0 and mem_addr=0.
REQ-025 rst asserted mid-transfer SHALL discard any pending fetch_rvalid; no write occurs after rst rises.

Structure
REQ-026 A shared package imem_pkg SHALL hold ADDR_W/DATA_W defaults and the typedef enum imem_ctrl_state_t {BOOT, RUN, FLUSH}.
REQ-027 The arbiter decision (streak counter plus priority) SHALL be one sub-module, imem_arb; the FSM and read-return register stay in imem_ctrl.

Verification
REQ-028 Boot: after reset, fetch_req=1 held while 3 loads are made to addresses 0,1,2 with data 0x00000013, 0x00100093 and 0x00200113 (last on the third) -> no fetch_gnt; boot_done=1 the next cycle; a fetch of address 1 then returns rvalid with 0x00100093 one cycle later.
REQ-029 Starvation: RUN, load_req and fetch_req both held high -> grant pattern 4 loads, 1 fetch, repeating.
REQ-030 Wrap: 1024 loads with load_last=0 -> boot_done rises after the 1024th grant.
REQ-031 Reload: in RUN, a load with load_last=1 at cycle N -> no grants at N+1 and grants resume at N+2; a fetch granted at N-1 still returns rvalid at N.
REQ-032 Reset mid-read: a fetch granted, then rst pulsed the next cycle -> fetch_rvalid=0, state=BOOT, boot_done=0.
REQ-033 RAW: a load of 0xDEADBEEF to address 5, then a fetch of address 5 -> fetch_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory controller.
// Holds the default widths and the controller state encoding.
package imem_pkg;

  localparam int IMEM_ADDR_W     = 10;
  localparam int IMEM_DATA_W     = 32;
  localparam int IMEM_MAX_STREAK = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } imem_ctrl_state_t;

endpackage

// File: rtl/imem_arb.sv
// Run-mode arbiter between the loader and the fetch port.
// Ports: clk, rst, run (arbitrate enable), fetch_req, load_req in;
// fetch_gnt, load_gnt out (combinational, at most one high).
module imem_arb #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic fetch_req,
  input  logic load_req,
  output logic fetch_gnt,
  output logic load_gnt
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak;
  logic          starve;

  // Loader wins unless the waiting fetch has been passed over too often.
  assign starve    = fetch_req && (streak == SMAX);
  assign fetch_gnt = run && fetch_req && (starve || !load_req);
  assign load_gnt  = run && load_req && !starve;

  // Only run-mode grants count; boot-time loads never build a streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (run) begin
      if (fetch_gnt || !fetch_req)
        streak <= '0;
      else if (load_gnt && streak != SMAX)
        streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: boot loader, fetch/load arbitration.
// Ports: fetch req/gnt/rvalid/rdata, loader req/gnt, single-port
// memory (mem_*, 1-cycle read), boot_done once the image is loaded.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int DATA_W     = IMEM_DATA_W,
  parameter int MAX_STREAK = IMEM_MAX_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  input  logic              load_last,
  output logic              load_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot_done
);

  imem_ctrl_state_t state, state_nxt;
  logic [ADDR_W-1:0] wcnt, wcnt_nxt;
  logic              run;
  logic              arb_fgnt, arb_lgnt;
  logic              rvalid_q;

  assign run = !rst && (state == RUN);

  imem_arb #(
    .MAX_STREAK(MAX_STREAK)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .fetch_req(fetch_req),
    .load_req (load_req),
    .fetch_gnt(arb_fgnt),
    .load_gnt (arb_lgnt)
  );

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    unique case (state)
      BOOT: begin
        load_gnt = !rst && load_req;
        if (load_gnt) begin
          wcnt_nxt = wcnt + 1'b1;
          // Counter wrap means every word has been written.
          if (load_last || (wcnt == '1)) begin
            state_nxt = RUN;
            wcnt_nxt  = '0;
          end
        end
      end
      RUN: begin
        fetch_gnt = arb_fgnt;
        load_gnt  = arb_lgnt;
        if (load_gnt && load_last)
          state_nxt = FLUSH;
      end
      FLUSH: state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      wcnt     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      rvalid_q <= fetch_gnt;
    end
  end

  assign mem_en    = fetch_gnt || load_gnt;
  assign mem_we    = load_gnt;
  assign mem_addr  = load_gnt  ? load_addr  :
                     fetch_gnt ? fetch_addr : '0;
  assign mem_wdata = load_gnt  ? load_wdata : '0;

  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = rvalid_q ? mem_rdata : '0;
  assign boot_done    = (state != BOOT);

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a synchronous single-port RAM.
// Covers reset, boot, starvation, RAW, reload, reset abort, wrap.
module tb_imem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        load_req;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;
  logic        load_last;
  logic        load_gnt;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        boot_done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ram [1024];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  imem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata (fetch_rdata),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_wdata  (load_wdata),
    .load_last   (load_last),
    .load_gnt    (load_gnt),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .boot_done   (boot_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] boot_img [3];
  logic [1:0]  pat [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    boot_img[0] = 32'h0000_0013;
    boot_img[1] = 32'h0010_0093;
    boot_img[2] = 32'h0020_0113;
    for (int i = 0; i < 10; i++)
      pat[i] = (i % 5 == 4) ? 2'b10 : 2'b01;

    rst = 1'b1;
    fetch_req = 1'b1; fetch_addr = '0;
    load_req = 1'b1; load_addr = '0;
    load_wdata = '0; load_last = 1'b0;
    tick();
    settle();
    chk("rst_boot_done", boot_done, 0);
    chk("rst_gnts", {fetch_gnt, load_gnt}, 0);
    chk("rst_mem", {mem_en, mem_we}, 0);
    chk("rst_rvalid", fetch_rvalid, 0);
    chk("rst_rdata", fetch_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;
    load_req = 1'b0;
    tick();

    // Boot with a fetch request held the whole time.
    fetch_addr = 10'd1;
    for (int i = 0; i < 3; i++) begin
      load_req = 1'b1; load_addr = 10'(i);
      load_wdata = boot_img[i]; load_last = (i == 2);
      settle();
      chk("boot_lgnt", load_gnt, 1);
      chk("boot_fgnt", fetch_gnt, 0);
      chk("boot_we", mem_we, 1);
      chk("boot_done_early", boot_done, 0);
      tick();
    end
    load_req = 1'b0; load_last = 1'b0;
    settle();
    chk("boot_done", boot_done, 1);
    chk("run_fgnt", fetch_gnt, 1);
    chk("run_faddr", mem_addr, 1);
    chk("run_fwe", mem_we, 0);
    tick();
    fetch_req = 1'b0;
    settle();
    chk("boot_rvalid", fetch_rvalid, 1);
    chk("boot_rdata", fetch_rdata, 32'h0010_0093);
    tick();
    settle();
    chk("idle_mem_en", mem_en, 0);

    // Starvation: both held high.
    load_req = 1'b1; load_addr = 10'd10; load_wdata = 32'h1111_1111;
    fetch_req = 1'b1; fetch_addr = 10'd0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("starve_%0d", i), {fetch_gnt, load_gnt}, pat[i]);
      tick();
    end
    load_req = 1'b0; fetch_req = 1'b0;
    tick();

    // Write then immediate read of the same word.
    load_req = 1'b1; load_addr = 10'd5; load_wdata = 32'hDEAD_BEEF;
    settle();
    chk("raw_lgnt", load_gnt, 1);
    tick();
    load_req = 1'b0; fetch_req = 1'b1; fetch_addr = 10'd5;
    settle();
    chk("raw_fgnt", fetch_gnt, 1);
    tick();
    fetch_req = 1'b0;
    settle();
    chk("raw_rvalid", fetch_rvalid, 1);
    chk("raw_rdata", fetch_rdata, 32'hDEAD_BEEF);
    tick();

    // Reload: fetch at N-1, last load at N, flush at N+1.
    fetch_req = 1'b1; fetch_addr = 10'd0;
    settle();
    chk("rl_fgnt", fetch_gnt, 1);
    tick();
    fetch_req = 1'b0;
    load_req = 1'b1; load_addr = 10'd7;
    load_wdata = 32'h7777_7777; load_last = 1'b1;
    settle();
    chk("rl_lgnt", load_gnt, 1);
    chk("rl_rvalid", fetch_rvalid, 1);
    chk("rl_rdata", fetch_rdata, 32'h0000_0013);
    tick();
    load_last = 1'b0; fetch_req = 1'b1;
    settle();
    chk("flush_gnts", {fetch_gnt, load_gnt}, 0);
    chk("flush_mem_en", mem_en, 0);
    chk("flush_rvalid", fetch_rvalid, 0);
    tick();
    settle();
    chk("resume_lgnt", load_gnt, 1);
    chk("resume_boot", boot_done, 1);
    tick();
    load_req = 1'b0; fetch_req = 1'b0;
    tick();

    // Reset right after a fetch grant drops the return.
    fetch_req = 1'b1; fetch_addr = 10'd1;
    settle();
    chk("rr_fgnt", fetch_gnt, 1);
    tick();
    rst = 1'b1; fetch_req = 1'b0;
    settle();
    chk("rr_rvalid", fetch_rvalid, 0);
    chk("rr_rdata", fetch_rdata, 0);
    chk("rr_boot", boot_done, 0);
    tick();
    rst = 1'b0;
    tick();

    // Fill all 1024 words without load_last.
    for (int i = 0; i < 1024; i++) begin
      load_req = 1'b1; load_addr = 10'(i);
      load_wdata = 32'(i) ^ 32'hA500_0000; load_last = 1'b0;
      if (i == 1023) begin
        settle();
        chk("wrap_pre_boot", boot_done, 0);
        chk("wrap_last_lgnt", load_gnt, 1);
      end
      tick();
    end
    load_req = 1'b0;
    settle();
    chk("wrap_boot", boot_done, 1);
    fetch_req = 1'b1; fetch_addr = 10'd3;
    settle();
    chk("wrap_fgnt", fetch_gnt, 1);
    tick();
    fetch_req = 1'b0;
    settle();
    chk("wrap_rdata", fetch_rdata, 32'hA500_0003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
